seq_mult_unit: RTL and testbench

//  Iterative radix-2 shift-and-add multiplier for MULT/MULTU; writes the HI/LO pair.

---
 rtl/seq_mult_unit.sv | 98 +++++++++
 tb/tb_seq_mult_unit.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative radix-2 shift-and-add multiplier for MULT/MULTU writing HI/LO
// Ports: i_clk clock; i_rst_n async active-low reset; i_start/i_signed/i_a/i_b request
//   (sampled in IDLE); i_flush abort; o_busy high in CALC/FIX/DONE; o_done one-cycle
//   result strobe; o_hi/o_lo product halves, held until the next completed op.
// Optional MULT_EARLY_TERM_EN: finish the step loop as soon as the remaining
//   multiplier bits are all zero, shifting the accumulator into place in one cycle.
module seq_mult_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] mcand, mplr, acc_hi, acc_lo, addend, sum, mag_a, mag_b;
  logic [WIDTH:0] carry;
  logic [CNT_W-1:0] cnt;
  logic neg, last;
  logic [2*WIDTH-1:0] step, prod, fixed;
  // Magnitudes are held unsigned, so -2^(W-1) maps to 2^(W-1) without overflow.
  assign mag_a = (i_signed && i_a[WIDTH-1]) ? -i_a : i_a;
  assign mag_b = (i_signed && i_b[WIDTH-1]) ? -i_b : i_b;
  assign addend = mplr[0] ? mcand : '0;
  assign carry[0] = 1'b0;
  // Ripple chain of full-adder cells; its carry-out becomes the next product MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : fa
    assign sum[i] = acc_hi[i] ^ addend[i] ^ carry[i];
    assign carry[i+1] = (acc_hi[i] & addend[i]) | (carry[i] & (acc_hi[i] ^ addend[i]));
  end
  assign step = {carry[WIDTH], sum, acc_lo[WIDTH-1:1]};
`ifdef MULT_EARLY_TERM_EN
  // Once no multiplier bits remain, later steps only shift; do them all at once.
  assign last = (cnt == CNT_W'(1)) || (mplr[WIDTH-1:1] == '0);
  assign prod = step >> (cnt - CNT_W'(1));
`else
  assign last = (cnt == CNT_W'(1));
  assign prod = step;
`endif
  assign fixed = neg ? ~{acc_hi, acc_lo} + (2*WIDTH)'(1) : {acc_hi, acc_lo};
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_hi   <= '0;
      o_lo   <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplr   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
    end else if (i_flush) begin
      state  <= IDLE;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          mcand  <= mag_a;
          mplr   <= mag_b;
          neg    <= i_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
          acc_hi <= '0;
          acc_lo <= '0;
          cnt    <= CNT_W'(WIDTH);
          o_busy <= 1'b1;
          state  <= CALC;
        end
        CALC: begin
          {acc_hi, acc_lo} <= prod;
          mplr  <= mplr >> 1;
          cnt   <= last ? '0 : cnt - CNT_W'(1);
          state <= last ? FIX : CALC;
        end
        FIX: begin
          {o_hi, o_lo} <= fixed;
          o_done <= 1'b1;
          state  <= DONE;
        end
        default: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_unit.sv
// tb_seq_mult_unit: randomized and directed checks of seq_mult_unit against an arithmetic model
module tb_seq_mult_unit;
  localparam int W = 32;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, sgn = 1'b0, flush = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic busy, done;
  logic [W-1:0] hi, lo;
  logic [2*W-1:0] last_p = '0;
  int checks = 0, errors = 0;
  seq_mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn),
    .i_a(a_in), .i_b(b_in), .i_flush(flush),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return s ? (2*W)'(sa * sb) : {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction
  function automatic int exp_lat(input logic s, input logic [W-1:0] b);
    logic [W-1:0] m;
    int k;
    m = (s && b[W-1]) ? -b : b;
    k = 1;
    for (int i = 0; i < W; i++) if (m[i]) k = i + 1;
    return EARLY ? k + 2 : W + 2;
  endfunction
  function automatic logic [W-1:0] pick();
    logic [W-1:0] edges [5];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    case ($urandom_range(0, 2))
      0: return W'($urandom);
      1: return edges[$urandom_range(0, 4)];
      default: return W'($urandom_range(0, 255));
    endcase
  endfunction
  task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    sgn = s;
    a_in = a;
    b_in = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic finish_op(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input int poke_at);
    int n;
    logic [2*W-1:0] p;
    p = ref_prod(s, a, b);
    n = 1;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    while (!done && n < 200) begin
      if (n == poke_at) begin
        start = 1'b1;
        sgn = ~s;
        a_in = ~a;
        b_in = ~b;
      end else start = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check({tag, "_lat"}, 64'(n), 64'(exp_lat(s, b)));
    check({tag, "_hi"}, 64'(hi), 64'(p[2*W-1:W]));
    check({tag, "_lo"}, 64'(lo), 64'(p[W-1:0]));
    last_p = p;
    start = 1'b1;
    a_in = W'($urandom);
    b_in = W'($urandom);
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
  endtask
  initial begin
    int extra;
    logic s;
    logic [W-1:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", {62'd0, busy, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check("multu_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0007);
    finish_op("mult_neg1x7", 1'b1, 32'hFFFF_FFFF, 32'h0000_0007, 0);
    check("mult_neg1x7_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF9);
    issue(1'b1, 32'h8000_0000, 32'h8000_0000);
    finish_op("mult_min", 1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    check("mult_min_const", {hi, lo}, 64'h4000_0000_0000_0000);
    issue(1'b0, 32'h1234_5678, 32'h0000_0003);
    finish_op("early", 1'b0, 32'h1234_5678, 32'h0000_0003, 0);
    check("early_const", {hi, lo}, 64'h0000_0000_369D_0368);
    check("early_lat_const", 64'(exp_lat(1'b0, 32'h3)), EARLY ? 64'd4 : 64'd34);
    issue(1'b1, 32'hFFFF_FF00, 32'h7654_3210);
    finish_op("busy_start", 1'b1, 32'hFFFF_FF00, 32'h7654_3210, 5);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check("busy_start_no_extra", 64'(extra), 64'd0);
    issue(1'b0, 32'hDEAD_BEEF, 32'h0000_1234);
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_state", {62'd0, busy, done}, 64'd0);
    check("flush_hold", {hi, lo}, last_p);
    issue(1'b0, 32'h0000_0100, 32'h0000_0020);
    finish_op("after_flush", 1'b0, 32'h0000_0100, 32'h0000_0020, 0);
    issue(1'b1, 32'h1234_5678, 32'h8765_4321);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out", {62'd0, busy, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    last_p = '0;
    @(posedge clk); #1;
    check("midrst_idle", {62'd0, busy, done}, 64'd0);
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      issue(s, a, b);
      finish_op("rnd", s, a, b, 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
